cfg_chain_loader: RTL and testbench

Serial configuration-chain writer for the APIR-DSP tile. It accepts a configuration image as a stream of parallel words and shifts it bit-serially into the daisy-chained `configuration_input` / `configuration_enable` / `configuration_output` ports of the DSP sub-blocks, such as `XORSIMD` and its neighbours. While it shifts the new image in, it captures the bits falling out of the chain tail and returns the previous image as readback words. It sits between the fabric-side configuration controller and the head of a tile's configuration chain.

---
 rtl/cfg_chain_loader.sv | 108 ++++++++++
 tb/tb_cfg_chain_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: shifts a word-streamed image bit-serially into a config chain while capturing the previous image as readback
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   start                        : request an image load (sampled in IDLE only)
//   cfg_data, cfg_valid, cfg_ready : image word stream, one word per handshake
//   configuration_input          : registered serial bit to the chain head
//   configuration_enable         : registered chain shift enable
//   configuration_output         : chain tail bit
//   rb_data, rb_valid            : previous-image readback word and its one-cycle strobe
//   busy, done                   : load in progress, one-cycle completion pulse
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              configuration_input,
    output logic              configuration_enable,
    input  logic              configuration_output,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_N = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int BW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_n;
    logic [BW-1:0]     bidx;
    logic [WW-1:0]     wcnt;
    logic              last_word;
    logic              last_bit;
    // the final word may be short; bits past CHAIN_LEN are never shifted
    assign last_word = wcnt == WW'(NWORDS - 1);
    assign last_bit  = bidx == (last_word ? BW'(LAST_N - 1) : BW'(WORD_W - 1));
    // readback word including the tail bit sampled on this edge
    always_comb begin
        acc_n       = acc;
        acc_n[bidx] = configuration_output;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= IDLE;
            cfg_ready            <= 1'b0;
            configuration_input  <= 1'b0;
            configuration_enable <= 1'b0;
            rb_data              <= '0;
            rb_valid             <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            shreg                <= '0;
            acc                  <= '0;
            bidx                 <= '0;
            wcnt                 <= '0;
        end else begin
            rb_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= FETCH;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b1;
                    wcnt      <= '0;
                end
                FETCH: if (cfg_valid && cfg_ready) begin
                    state                <= SHIFT;
                    cfg_ready            <= 1'b0;
                    configuration_enable <= 1'b1;
                    configuration_input  <= cfg_data[0];
                    shreg                <= cfg_data >> 1;
                    bidx                 <= '0;
                    acc                  <= '0;
                end
                SHIFT: begin
                    acc   <= acc_n;
                    shreg <= shreg >> 1;
                    bidx  <= bidx + 1'b1;
                    if (last_bit) begin
                        // chain holds between words; the head bit keeps its last value
                        configuration_enable <= 1'b0;
                        rb_data              <= acc_n;
                        rb_valid             <= 1'b1;
                        wcnt                 <= wcnt + 1'b1;
                        state                <= last_word ? DONE : FETCH;
                        cfg_ready            <= !last_word;
                        done                 <= last_word;
                    end else begin
                        configuration_input <= shreg[0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: scoreboard bench for cfg_chain_loader with chain models for a 40-flop and a 1-flop chain
module tb_cfg_chain_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, cfg_valid = 1'b0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ready, ci, ce, co, rb_valid, busy, done;
    logic [15:0] rb_data;
    logic        start1 = 1'b0, valid1 = 1'b0;
    logic [15:0] data1 = '0;
    logic        ready1, ci1, ce1, co1, rbv1, busy1, done1;
    logic [15:0] rb1;
    logic [39:0] chain = 40'hC35A960FE1;
    logic        chain1 = 1'b0;
    int          cyc = 0, t0 = 0, en_cnt = 0, en1 = 0, errors = 0, checks = 0;
    typedef struct {logic [15:0] data; int cyc;} sb_t;
    sb_t         sb[$];

    always #5 clk = ~clk;

    cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .configuration_input(ci),
        .configuration_enable(ce), .configuration_output(co), .rb_data(rb_data),
        .rb_valid(rb_valid), .busy(busy), .done(done)
    );

    cfg_chain_loader #(.CHAIN_LEN(1), .WORD_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .cfg_data(data1),
        .cfg_valid(valid1), .cfg_ready(ready1), .configuration_input(ci1),
        .configuration_enable(ce1), .configuration_output(co1), .rb_data(rb1),
        .rb_valid(rbv1), .busy(busy1), .done(done1)
    );

    // chain models: head is position 0, tail is the highest position
    assign co  = chain[39];
    assign co1 = chain1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ce === 1'b1) begin
            chain  <= {chain[38:0], ci};
            en_cnt <= en_cnt + 1;
        end
        if (ce1 === 1'b1) begin
            chain1 <= ci1;
            en1    <= en1 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] chain_of(input logic [15:0] a, b, c);
        logic [47:0] img;
        logic [39:0] r;
        img = {c, b, a};
        for (int p = 0; p < 40; p++) r[p] = img[39-p];
        return r;
    endfunction

    function automatic logic [15:0] rb_word(input logic [39:0] ch, input int w);
        logic [15:0] r;
        for (int b = 0; b < 16; b++) r[b] = (w*16 + b < 40) ? ch[39-(w*16+b)] : 1'b0;
        return r;
    endfunction

    always @(negedge clk) begin : mon
        sb_t e;
        if (rb_valid === 1'b1) begin
            if (sb.size() == 0) check("rb_extra", 1, 0);
            else begin
                e = sb.pop_front();
                check("rb_data", rb_data, e.data);
                if (e.cyc >= 0) check("rb_cyc", cyc - t0, e.cyc);
            end
        end
    end

    task automatic load(input logic [15:0] a, b, c, input int maxgap, input bit poke);
        logic [15:0] w[3];
        int gap, gtot, n, e0;
        w[0] = a; w[1] = b; w[2] = c;
        gtot = 0;
        for (int k = 0; k < 3; k++)
            sb.push_back('{rb_word(chain, k), maxgap == 0 ? (k < 2 ? 17*k + 18 : 44) : -1});
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        e0 = en_cnt;
        for (int k = 0; k < 3; k++) begin
            gap = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
            gtot += gap;
            cfg_data = w[k];
            cfg_valid = (gap == 0);
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!cfg_ready && n < 64) begin
                @(negedge clk);
                n++;
            end
            check("fetch_wait", n < 64, 1);
            check("busy_fetch", busy, 1);
            repeat (gap) begin
                check("gap_en", ce, 0);
                @(negedge clk);
            end
            cfg_valid = 1'b1;
            if (poke && k == 1) start = 1'b1;
            @(negedge clk);
            check("shift_en", ce, 1);
        end
        cfg_valid = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", n < 64, 1);
        check("done_cyc", cyc - t0, 44 + gtot);
        check("busy_done", busy, 1);
        check("en_total", en_cnt - e0, 40);
        check("chain", chain, chain_of(a, b, c));
        @(negedge clk);
        check("busy_after", busy, 0);
        check("done_pulse", done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, seen, t1, e1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_out", {cfg_ready, ci, ce, rb_valid, busy, done, rb_data}, 0);
            check("rst_out1", {ready1, ci1, ce1, rbv1, busy1, done1, rb1}, 0);
            start = 1'($urandom_range(0, 1));
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data = 16'($urandom);
            start1 = 1'($urandom_range(0, 1));
            valid1 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_out", {cfg_ready, ci, ce, rb_valid, busy, done, rb_data}, 0);
        check("rst_chain", chain, 40'hC35A960FE1);
        start = 1'b0; cfg_valid = 1'b0; start1 = 1'b0; valid1 = 1'b0;
        reset_n = 1'b1;

        load(16'hBEEF, 16'h1234, 16'h00A5, 0, 1'b0);
        load(16'h0F0F, 16'hFFFF, 16'hFF3C, 0, 1'b0);
        load(16'h5A3C, 16'hC001, 16'h7E81, 5, 1'b0);

        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 16'hFFFF; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 12) @(negedge clk);
        check("mid_en", ce, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst", {busy, ce, cfg_ready, done, rb_valid}, 0);
        reset_n = 1'b1;
        cfg_valid = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            seen |= int'(done);
        end
        check("mid_nodone", seen, 0);
        load(16'h9C3A, 16'h0001, 16'h8080, 0, 1'b1);

        @(negedge clk);
        start1 = 1'b1; valid1 = 1'b1; data1 = 16'h0001; t1 = cyc; e1 = en1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("l1_done_cyc", cyc - t1, 3);
        check("l1_en", en1 - e1, 1);
        check("l1_xorsimd", chain1, 1);
        check("l1_rbv", rbv1, 1);
        check("l1_rb", rb1, 0);
        valid1 = 1'b0;

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
